// File: rtl/xor_pkg.sv
// rtl/xor_pkg.sv - keystream mode enum, seed constant and key-advance function shared by xor_gen and xor_dec
package xor_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    ROLL  = 2'd1,
    LFSR  = 2'd2
  } xor_mode_e;

  localparam logic [7:0] KEY_SEED_DEFAULT = 8'hA5;

  // Single definition of the key step so encryptor and decryptor cannot drift apart.
  function automatic logic [7:0] next_key(input xor_mode_e mode, input logic [7:0] key);
    case (mode)
      ROLL:    return {key[6:0], key[7]};
      LFSR:    return {key[6:0], key[7] ^ key[5] ^ key[4] ^ key[3]};
      default: return key;
    endcase
  endfunction

endpackage

// File: rtl/xor_dec_if.sv
// rtl/xor_dec_if.sv - ciphertext-in / plaintext-out valid/ready bundle for xor_dec
interface xor_dec_if;
  logic [7:0] ciphertext;
  logic       ct_valid;
  logic       ct_ready;
  logic [7:0] plaintext;
  logic       pt_valid;
  logic       pt_ready;

  modport slave (
    input  ciphertext, ct_valid, pt_ready,
    output ct_ready, plaintext, pt_valid
  );

  modport master (
    output ciphertext, ct_valid, pt_ready,
    input  ct_ready, plaintext, pt_valid
  );
endinterface

// File: rtl/xor_keystream.sv
// rtl/xor_keystream.sv - key register with per-byte advance, resync reload and MODE decode
module xor_keystream
  import xor_pkg::*;
#(
  parameter int         MODE     = 0,
  parameter logic [7:0] KEY_SEED = KEY_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance_i,
  input  logic       resync_i,
  output logic [7:0] key_o
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("xor_keystream: MODE %0d is not supported (legal: 0, 1, 2)", MODE);
  end

  localparam xor_mode_e MODE_E = xor_mode_e'(MODE[1:0]);

  logic [7:0] key_q;
  logic [7:0] key_d;

  // Resync outranks advance; the byte accepted alongside it already used key_q.
  always_comb begin
    key_d = key_q;
    if (resync_i) begin
      key_d = KEY_SEED;
    end else if (advance_i) begin
      key_d = next_key(MODE_E, key_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= KEY_SEED;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_o = key_q;

endmodule

// File: rtl/xor_dec.sv
// rtl/xor_dec.sv - streaming XOR decryptor with registered output; XOR_DEC_CNT_EN adds dec_count
module xor_dec
  import xor_pkg::*;
#(
  parameter int         MODE     = 0,
  parameter logic [7:0] KEY_SEED = KEY_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resync,
  xor_dec_if.slave    bus
`ifdef XOR_DEC_CNT_EN
  ,
  output logic [15:0] dec_count
`endif
);

  logic [7:0] key;
  logic       accept;
  logic       drain;
  logic [7:0] plaintext_q;
  logic [7:0] plaintext_d;
  logic       pt_valid_q;
  logic       pt_valid_d;

  // Single output register: room exists only when empty or draining this cycle.
  assign bus.ct_ready = !rst && (!pt_valid_q || bus.pt_ready);
  assign accept       = bus.ct_valid && bus.ct_ready;
  assign drain        = pt_valid_q && bus.pt_ready;

  xor_keystream #(
    .MODE     (MODE),
    .KEY_SEED (KEY_SEED)
  ) u_keystream (
    .clk       (clk),
    .rst       (rst),
    .advance_i (accept),
    .resync_i  (resync),
    .key_o     (key)
  );

  always_comb begin
    plaintext_d = plaintext_q;
    pt_valid_d  = pt_valid_q;
    if (accept) begin
      plaintext_d = bus.ciphertext ^ key;
      pt_valid_d  = 1'b1;
    end else if (drain) begin
      pt_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plaintext_q <= 8'h00;
      pt_valid_q  <= 1'b0;
    end else begin
      plaintext_q <= plaintext_d;
      pt_valid_q  <= pt_valid_d;
    end
  end

  assign bus.plaintext = plaintext_q;
  assign bus.pt_valid  = pt_valid_q;

`ifdef XOR_DEC_CNT_EN
  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (drain) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign dec_count = count_q;
`endif

endmodule

// File: tb/tb_xor_dec.sv
// tb/tb_xor_dec.sv - directed-vector bench for xor_dec in MODE 0, 1 and 2
module tb_xor_dec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       resync;
  logic [7:0] ct       [3];
  logic       ct_valid [3];
  logic       pt_ready [3];
  wire  [7:0] pt       [3];
  wire        pt_valid [3];
  wire        ct_ready [3];
`ifdef XOR_DEC_CNT_EN
  wire [15:0] cnt      [3];
`endif

  int n_err = 0;
  int n_chk = 0;

  xor_dec_if if0 ();
  xor_dec_if if1 ();
  xor_dec_if if2 ();

  assign if0.ciphertext = ct[0];
  assign if0.ct_valid   = ct_valid[0];
  assign if0.pt_ready   = pt_ready[0];
  assign pt[0]          = if0.plaintext;
  assign pt_valid[0]    = if0.pt_valid;
  assign ct_ready[0]    = if0.ct_ready;

  assign if1.ciphertext = ct[1];
  assign if1.ct_valid   = ct_valid[1];
  assign if1.pt_ready   = pt_ready[1];
  assign pt[1]          = if1.plaintext;
  assign pt_valid[1]    = if1.pt_valid;
  assign ct_ready[1]    = if1.ct_ready;

  assign if2.ciphertext = ct[2];
  assign if2.ct_valid   = ct_valid[2];
  assign if2.pt_ready   = pt_ready[2];
  assign pt[2]          = if2.plaintext;
  assign pt_valid[2]    = if2.pt_valid;
  assign ct_ready[2]    = if2.ct_ready;

  xor_dec #(.MODE(0)) u_dec0 (
    .clk    (clk),
    .rst    (rst),
    .resync (resync),
    .bus    (if0)
`ifdef XOR_DEC_CNT_EN
    ,
    .dec_count (cnt[0])
`endif
  );

  xor_dec #(.MODE(1)) u_dec1 (
    .clk    (clk),
    .rst    (rst),
    .resync (resync),
    .bus    (if1)
`ifdef XOR_DEC_CNT_EN
    ,
    .dec_count (cnt[1])
`endif
  );

  xor_dec #(.MODE(2)) u_dec2 (
    .clk    (clk),
    .rst    (rst),
    .resync (resync),
    .bus    (if2)
`ifdef XOR_DEC_CNT_EN
    ,
    .dec_count (cnt[2])
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int m = 0; m < 3; m++) ct_valid[m] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] rs_ct  [5];
  logic [7:0] rs_exp [5];

  initial begin
    rst    = 1'b1;
    resync = 1'b0;
    for (int m = 0; m < 3; m++) begin
      ct[m] = 8'h00; ct_valid[m] = 1'b0; pt_ready[m] = 1'b0;
    end
    tick();
    tick();

    for (int m = 0; m < 3; m++) begin
      check($sformatf("m%0d_rst_pt_valid", m), 16'(pt_valid[m]), 16'h0);
      check($sformatf("m%0d_rst_plaintext", m), 16'(pt[m]), 16'h00);
      check($sformatf("m%0d_rst_ct_ready", m), 16'(ct_ready[m]), 16'h0);
    end
    rst = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) check($sformatf("m%0d_ct_ready_idle", m), 16'(ct_ready[m]), 16'h1);

    // Back-to-back pair per mode; every mode decodes both bytes to B1.
    for (int m = 0; m < 3; m++) begin
      pt_ready[m] = 1'b1; ct[m] = 8'h14; ct_valid[m] = 1'b1;
    end
    tick();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("m%0d_first_pt", m), 16'(pt[m]), 16'h00B1);
      check($sformatf("m%0d_first_valid", m), 16'(pt_valid[m]), 16'h1);
    end
    ct[0] = 8'h14; ct[1] = 8'hFA; ct[2] = 8'hFB;
    tick();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("m%0d_second_pt", m), 16'(pt[m]), 16'h00B1);
      check($sformatf("m%0d_second_valid", m), 16'(pt_valid[m]), 16'h1);
      ct_valid[m] = 1'b0;
    end
    tick();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("m%0d_drained", m), 16'(pt_valid[m]), 16'h0);
`ifdef XOR_DEC_CNT_EN
      check($sformatf("m%0d_count_two", m), cnt[m], 16'd2);
`endif
    end

    // Backpressure in MODE 1: hold A5 (00 ^ A5) while FA waits for key 4B.
    do_reset();
    pt_ready[1] = 1'b0; ct[1] = 8'h00; ct_valid[1] = 1'b1;
    tick();
    check("bp_first_pt", 16'(pt[1]), 16'h00A5);
    ct[1] = 8'hFA;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_ct_ready_c%0d", i), 16'(ct_ready[1]), 16'h0);
      check($sformatf("bp_pt_hold_c%0d", i), 16'(pt[1]), 16'h00A5);
      check($sformatf("bp_valid_hold_c%0d", i), 16'(pt_valid[1]), 16'h1);
      tick();
    end
    pt_ready[1] = 1'b1;
    #1;
    check("bp_ct_ready_release", 16'(ct_ready[1]), 16'h1);
    tick();
    check("bp_after_pt", 16'(pt[1]), 16'h00B1);
    check("bp_after_valid", 16'(pt_valid[1]), 16'h1);
    ct_valid[1] = 1'b0;
    tick();
    check("bp_drained", 16'(pt_valid[1]), 16'h0);

    // MODE 2 resync: keys A5, 4A, 95, 2A (resync here), then back to A5.
    do_reset();
    rs_ct[0] = 8'h00; rs_ct[1] = 8'h00; rs_ct[2] = 8'h00; rs_ct[3] = 8'h00; rs_ct[4] = 8'h14;
    rs_exp[0] = 8'hA5; rs_exp[1] = 8'h4A; rs_exp[2] = 8'h95; rs_exp[3] = 8'h2A; rs_exp[4] = 8'hB1;
    pt_ready[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ct[2] = rs_ct[i]; ct_valid[2] = 1'b1; resync = (i == 3);
      tick();
      resync = 1'b0;
      check($sformatf("rs_byte%0d", i), 16'(pt[2]), 16'(rs_exp[i]));
    end
    ct_valid[2] = 1'b0;
    tick();

    // Reset while output is pending and stalled.
    for (int m = 0; m < 3; m++) begin
      pt_ready[m] = 1'b0; ct[m] = 8'h5A; ct_valid[m] = 1'b1;
    end
    tick();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("m%0d_pending", m), 16'(pt_valid[m]), 16'h1);
      ct_valid[m] = 1'b0;
    end
    rst = 1'b1;
    tick();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("m%0d_midrst_valid", m), 16'(pt_valid[m]), 16'h0);
      check($sformatf("m%0d_midrst_ct_ready", m), 16'(ct_ready[m]), 16'h0);
`ifdef XOR_DEC_CNT_EN
      check($sformatf("m%0d_midrst_count", m), cnt[m], 16'd0);
`endif
    end
    rst = 1'b0;
    for (int m = 0; m < 3; m++) begin
      pt_ready[m] = 1'b1; ct[m] = 8'h14; ct_valid[m] = 1'b1;
    end
    tick();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("m%0d_post_rst_pt", m), 16'(pt[m]), 16'h00B1);
      ct_valid[m] = 1'b0;
    end
    tick();
`ifdef XOR_DEC_CNT_EN
    for (int m = 0; m < 3; m++) check($sformatf("m%0d_count_one", m), cnt[m], 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
